// File: rtl/grid_render_ctrl_pkg.sv
// Shared constants, colour codes and state encoding for the grid renderer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package grid_render_ctrl_pkg;

   localparam int GRID_SIZE     = 28;
   localparam int PIXEL_SIZE    = 4;
   localparam int GRID_OFFSET_X = 10;
   localparam int GRID_OFFSET_Y = 4;
   localparam int GRID_CELLS    = GRID_SIZE * GRID_SIZE;

   localparam logic [2:0] CURSOR = 3'b100;
   localparam logic [2:0] INK    = 3'b000;
   localparam logic [2:0] BG     = 3'b111;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_READ,
      S_LATCH,
      S_PLOT,
      S_DONE
   } state_t;

endpackage

// File: rtl/grid_render_ctrl_block_plotter.sv
// Sweeps one cell's PIXEL_SIZE x PIXEL_SIZE pixel block, sx fastest then sy.
// Latency: first plot one cycle after i_start, block takes PIXEL_SIZE^2 cycles.
// Backpressure: none; o_done marks the final plot cycle of the sweep.
module grid_block_plotter
   import grid_render_ctrl_pkg::*;
#(
   parameter int PIX   = grid_render_ctrl_pkg::PIXEL_SIZE,
   parameter int OFS_X = grid_render_ctrl_pkg::GRID_OFFSET_X,
   parameter int OFS_Y = grid_render_ctrl_pkg::GRID_OFFSET_Y
) (
   input  logic       i_clock,
   input  logic       i_resetn,
   input  logic       i_start,
   input  logic [4:0] i_gx,
   input  logic [4:0] i_gy,
   output logic       o_plot,
   output logic [7:0] o_x,
   output logic [6:0] o_y,
   output logic       o_done
);

   localparam int            SW     = (PIX > 1) ? $clog2(PIX) : 1;
   localparam logic [SW-1:0] S_LAST = SW'(PIX - 1);

   logic          r_active;
   logic [SW-1:0] r_sx;
   logic [SW-1:0] r_sy;
   logic [7:0]    r_x;
   logic [6:0]    r_y;
   logic [7:0]    w_base_x;
   logic [6:0]    w_base_y;

   // Top-left pixel of the cell; the constant scale reduces to a shift.
   assign w_base_x = 8'(OFS_X) + 8'(i_gx) * 8'(PIX);
   assign w_base_y = 7'(OFS_Y) + 7'(i_gy) * 7'(PIX);

   // Step the pixel coordinates incrementally so no per-pixel add of sx/sy is needed.
   always_ff @(posedge i_clock) begin
      if (!i_resetn) begin
         r_active <= 1'b0;
         r_sx     <= '0;
         r_sy     <= '0;
         r_x      <= '0;
         r_y      <= '0;
      end else if (i_start) begin
         r_active <= 1'b1;
         r_sx     <= '0;
         r_sy     <= '0;
         r_x      <= w_base_x;
         r_y      <= w_base_y;
      end else if (r_active) begin
         if (r_sx == S_LAST) begin
            r_sx <= '0;
            r_x  <= r_x - 8'(PIX - 1);
            if (r_sy == S_LAST) begin
               r_active <= 1'b0;
            end else begin
               r_sy <= r_sy + SW'(1);
               r_y  <= r_y + 7'd1;
            end
         end else begin
            r_sx <= r_sx + SW'(1);
            r_x  <= r_x + 8'd1;
         end
      end
   end

   assign o_plot = r_active;
   assign o_x    = r_x;
   assign o_y    = r_y;
   assign o_done = r_active && (r_sx == S_LAST) && (r_sy == S_LAST);

endmodule

// File: rtl/grid_render_ctrl.sv
// Renders a GRID_SIZE^2 cell grid to a pixel plotter: clear, full redraw or single cell.
// Latency: 18 cycles per cell (read, latch, 16 plots) plus a one-cycle DONE.
// Backpressure: cell_req waits un-acked while busy; clear/redraw pulses are held as pending flags.
module grid_render_ctrl
   import grid_render_ctrl_pkg::*;
#(
   parameter int GRID_SIZE     = grid_render_ctrl_pkg::GRID_SIZE,
   parameter int PIXEL_SIZE    = grid_render_ctrl_pkg::PIXEL_SIZE,
   parameter int GRID_OFFSET_X = grid_render_ctrl_pkg::GRID_OFFSET_X,
   parameter int GRID_OFFSET_Y = grid_render_ctrl_pkg::GRID_OFFSET_Y
) (
   input  logic       i_clock,
   input  logic       i_resetn,
   input  logic       i_clear_req,
   input  logic       i_redraw_req,
   input  logic       i_cell_req,
   input  logic [4:0] i_cell_x,
   input  logic [4:0] i_cell_y,
   output logic       o_cell_ack,
   input  logic [4:0] i_cursor_x,
   input  logic [4:0] i_cursor_y,
   output logic [9:0] o_mem_addr,
   input  logic       i_mem_rdata,
   output logic       o_mem_we,
   output logic       o_mem_wdata,
   output logic [7:0] o_vga_x,
   output logic [6:0] o_vga_y,
   output logic [2:0] o_vga_colour,
   output logic       o_vga_plot,
   output logic       o_busy,
   output logic       o_done
);

   localparam logic [4:0] LAST_G = 5'(GRID_SIZE - 1);
   localparam logic [9:0] LAST_A = 10'(GRID_SIZE * GRID_SIZE - 1);

   state_t     r_state;
   logic       r_clr_pend;
   logic       r_rdr_pend;
   logic       r_full;
   logic       r_busy;
   logic       r_done;
   logic       r_mem_we;
   logic [4:0] r_gx;
   logic [4:0] r_gy;
   logic [9:0] r_addr;
   logic [2:0] r_colour;

   logic       w_clr_go;
   logic       w_rdr_go;
   logic       w_cell_go;
   logic       w_cell_ok;
   logic [9:0] w_cell_addr;
   logic       w_pl_start;
   logic       w_pl_done;

   // A request pulse in the IDLE cycle counts as pending so it beats a cell request.
   assign w_clr_go    = r_clr_pend | i_clear_req;
   assign w_rdr_go    = r_rdr_pend | i_redraw_req;
   assign w_cell_go   = i_resetn && (r_state == S_IDLE) && !w_clr_go && !w_rdr_go && i_cell_req;
   assign w_cell_ok   = (int'(i_cell_x) < GRID_SIZE) && (int'(i_cell_y) < GRID_SIZE);
   assign w_cell_addr = 10'(i_cell_y) * 10'(GRID_SIZE) + 10'(i_cell_x);
   assign w_pl_start  = (r_state == S_LATCH);

   // Main sequencer: request arbitration, clear sweep, per-cell read/latch/plot walk.
   always_ff @(posedge i_clock) begin
      if (!i_resetn) begin
         r_state    <= S_IDLE;
         r_clr_pend <= 1'b0;
         r_rdr_pend <= 1'b0;
         r_full     <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_mem_we   <= 1'b0;
         r_gx       <= '0;
         r_gy       <= '0;
         r_addr     <= '0;
         r_colour   <= '0;
      end else begin
         // A clear already running covers any clear or redraw that arrives meanwhile.
         if (i_clear_req && (r_state != S_CLEAR)) r_clr_pend <= 1'b1;
         if (i_redraw_req && (r_state != S_CLEAR)) r_rdr_pend <= 1'b1;
         case (r_state)
            S_IDLE: begin
               if (w_clr_go) begin
                  r_clr_pend <= 1'b0;
                  r_rdr_pend <= 1'b0;
                  r_addr     <= '0;
                  r_mem_we   <= 1'b1;
                  r_busy     <= 1'b1;
                  r_state    <= S_CLEAR;
               end else if (w_rdr_go) begin
                  r_rdr_pend <= 1'b0;
                  r_full     <= 1'b1;
                  r_gx       <= '0;
                  r_gy       <= '0;
                  r_addr     <= '0;
                  r_busy     <= 1'b1;
                  r_state    <= S_READ;
               end else if (w_cell_go) begin
                  r_full <= 1'b0;
                  r_gx   <= i_cell_x;
                  r_gy   <= i_cell_y;
                  r_busy <= 1'b1;
                  if (w_cell_ok) begin
                     r_addr  <= w_cell_addr;
                     r_state <= S_READ;
                  end else begin
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end
               end
            end
            S_CLEAR: begin
               if (r_addr == LAST_A) begin
                  r_mem_we <= 1'b0;
                  r_addr   <= '0;
                  r_full   <= 1'b1;
                  r_gx     <= '0;
                  r_gy     <= '0;
                  r_state  <= S_READ;
               end else begin
                  r_addr <= r_addr + 10'd1;
               end
            end
            S_READ: begin
               r_state <= S_LATCH;
            end
            S_LATCH: begin
               if ((r_gx == i_cursor_x) && (r_gy == i_cursor_y)) r_colour <= CURSOR;
               else if (i_mem_rdata)                               r_colour <= INK;
               else                                                r_colour <= BG;
               r_state <= S_PLOT;
            end
            S_PLOT: begin
               if (w_pl_done) begin
                  if (r_full && !((r_gx == LAST_G) && (r_gy == LAST_G))) begin
                     if (r_gx == LAST_G) begin
                        r_gx <= '0;
                        r_gy <= r_gy + 5'd1;
                     end else begin
                        r_gx <= r_gx + 5'd1;
                     end
                     r_addr  <= r_addr + 10'd1;
                     r_state <= S_READ;
                  end else begin
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   grid_block_plotter #(
      .PIX   (PIXEL_SIZE),
      .OFS_X (GRID_OFFSET_X),
      .OFS_Y (GRID_OFFSET_Y)
   ) u_plotter (
      .i_clock  (i_clock),
      .i_resetn (i_resetn),
      .i_start  (w_pl_start),
      .i_gx     (r_gx),
      .i_gy     (r_gy),
      .o_plot   (o_vga_plot),
      .o_x      (o_vga_x),
      .o_y      (o_vga_y),
      .o_done   (w_pl_done)
   );

   assign o_cell_ack   = w_cell_go;
   assign o_mem_addr   = r_addr;
   assign o_mem_we     = r_mem_we;
   assign o_mem_wdata  = 1'b0;
   assign o_vga_colour = r_colour;
   assign o_busy       = r_busy;
   assign o_done       = r_done;

endmodule

// File: tb/tb_grid_render_ctrl.sv
// Bench for grid_render_ctrl: directed and randomised operations against a cell-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_grid_render_ctrl;

   localparam int G  = 28;
   localparam int P  = 4;
   localparam int OX = 10;
   localparam int OY = 4;
   localparam int N  = G * G;

   logic       clk = 1'b0;
   logic       resetn, clear_req, redraw_req, cell_req;
   logic [4:0] cell_x, cell_y, cur_x, cur_y;
   logic       cell_ack;
   logic [9:0] mem_addr;
   logic       mem_rdata;
   logic       mem_we, mem_wdata;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] vga_colour;
   logic       vga_plot, busy, done;

   always #5 clk = ~clk;

   grid_render_ctrl dut (
      .i_clock      (clk),
      .i_resetn     (resetn),
      .i_clear_req  (clear_req),
      .i_redraw_req (redraw_req),
      .i_cell_req   (cell_req),
      .i_cell_x     (cell_x),
      .i_cell_y     (cell_y),
      .o_cell_ack   (cell_ack),
      .i_cursor_x   (cur_x),
      .i_cursor_y   (cur_y),
      .o_mem_addr   (mem_addr),
      .i_mem_rdata  (mem_rdata),
      .o_mem_we     (mem_we),
      .o_mem_wdata  (mem_wdata),
      .o_vga_x      (vga_x),
      .o_vga_y      (vga_y),
      .o_vga_colour (vga_colour),
      .o_vga_plot   (vga_plot),
      .o_busy       (busy),
      .o_done       (done)
   );

   // Grid memory seen by the DUT: synchronous read, bulk load when fill_req is set.
   logic env_mem  [0:N-1];
   logic fill_pat [0:N-1];
   logic fill_req = 1'b0;
   always @(posedge clk) begin
      if (fill_req) begin
         for (int i = 0; i < N; i++) env_mem[i] <= fill_pat[i];
      end else if (mem_we) begin
         env_mem[mem_addr] <= mem_wdata;
      end
      mem_rdata <= env_mem[mem_addr];
   end

   // Observed activity, sampled on the falling edge.
   logic [17:0] plots[$];
   int          wr_addr[$];
   int          n_ack = 0, n_done = 0, n_busy = 0, n_wr_bad = 0;
   always @(negedge clk) begin
      if (vga_plot) plots.push_back({vga_x, vga_y, vga_colour});
      if (cell_ack) n_ack++;
      if (done) n_done++;
      if (busy) n_busy++;
      if (mem_we) begin
         wr_addr.push_back(int'(mem_addr));
         if (mem_wdata !== 1'b0) n_wr_bad++;
      end
   end

   // Reference: what the grid should contain and which pixels each cell produces.
   bit          ref_mem [0:N-1];
   logic [17:0] exp_q[$];
   int          n_tests = 0, n_fail = 0;

   function automatic void model_cell(input int gx, input int gy, input int ux, input int uy);
      logic [2:0] c;
      if (gx < G && gy < G) begin
         if (gx == ux && gy == uy) c = 3'b100;
         else if (ref_mem[gy * G + gx]) c = 3'b000;
         else c = 3'b111;
         for (int sy = 0; sy < P; sy++)
            for (int sx = 0; sx < P; sx++)
               exp_q.push_back({8'(OX + P * gx + sx), 7'(OY + P * gy + sy), c});
      end
   endfunction

   function automatic void model_full(input int ux, input int uy);
      for (int gy = 0; gy < G; gy++)
         for (int gx = 0; gx < G; gx++)
            model_cell(gx, gy, ux, uy);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_plots(input string tag, input int base);
      int got, bad;
      got = plots.size() - base;
      bad = 0;
      check({tag, "_plot_count"}, got, exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got; i++)
         if (plots[base + i] !== exp_q[i]) bad++;
      check({tag, "_plot_mismatches"}, bad, 0);
      exp_q.delete();
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // kind: 0 all zero, 1 all one, 2 random
   task automatic load_mem(input int kind);
      for (int i = 0; i < N; i++) begin
         fill_pat[i] = (kind == 2) ? 1'($urandom_range(0, 1)) : 1'(kind);
         ref_mem[i]  = fill_pat[i];
      end
      fill_req = 1'b1;
      tick(1);
      fill_req = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int k;
      k = 0;
      @(negedge clk);
      while (busy !== 1'b0 && k < budget) begin
         @(negedge clk);
         k++;
      end
      check({tag, "_idle"}, busy, 0);
      tick(1);
   endtask

   task automatic do_cell(input string tag, input int x, input int y);
      int b_plot, b_ack, b_done, b_busy;
      b_plot = plots.size();
      b_ack  = n_ack;
      b_done = n_done;
      b_busy = n_busy;
      model_cell(x, y, int'(cur_x), int'(cur_y));
      cell_x   = 5'(x);
      cell_y   = 5'(y);
      cell_req = 1'b1;
      @(negedge clk);
      check({tag, "_ack_now"}, cell_ack, 1);
      @(posedge clk);
      #1;
      cell_req = 1'b0;
      wait_idle(tag, 100);
      check({tag, "_ack_count"}, n_ack - b_ack, 1);
      check({tag, "_done_count"}, n_done - b_done, 1);
      check({tag, "_busy_cycles"}, n_busy - b_busy, (x < G && y < G) ? 19 : 1);
      check_plots(tag, b_plot);
   endtask

   int b_plot, b_done, b_busy, b_wr, cnt, rx, ry;

   initial begin
      resetn = 1'b0; clear_req = 1'b0; redraw_req = 1'b0;
      cell_req = 1'b1; cell_x = 5'd1; cell_y = 5'd1;
      cur_x = 5'd0; cur_y = 5'd0;

      // Reset state, with a cell request held that must not be acked.
      tick(3);
      @(negedge clk);
      check("rst_ack", cell_ack, 0);
      check("rst_busy", busy, 0);
      check("rst_plot", vga_plot, 0);
      check("rst_done", done, 0);
      check("rst_we", mem_we, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_vga_x", vga_x, 0);
      check("rst_vga_y", vga_y, 0);
      check("rst_colour", vga_colour, 0);
      tick(1);
      cell_req = 1'b0;
      resetn   = 1'b1;
      tick(2);
      check("rst_release_no_work", n_done, 0);

      // Single cell, inked, cursor elsewhere; then the cursor on it.
      load_mem(1);
      do_cell("cell_ink", 3, 5);
      cur_x = 5'd3; cur_y = 5'd5;
      do_cell("cell_cursor", 3, 5);

      // Edge cells and out-of-range coordinates.
      load_mem(2);
      cur_x = 5'd0; cur_y = 5'd0;
      do_cell("cell_last", 27, 27);
      do_cell("cell_x28", 28, 3);
      do_cell("cell_y31", 3, 31);
      do_cell("cell_origin", 0, 0);

      // Random cells, random cursor (sometimes on the cell).
      for (int t = 0; t < 8; t++) begin
         rx = $urandom_range(0, 31);
         ry = $urandom_range(0, 31);
         if ($urandom_range(0, 3) == 0) begin
            cur_x = 5'(rx); cur_y = 5'(ry);
         end else begin
            cur_x = 5'($urandom_range(0, 27)); cur_y = 5'($urandom_range(0, 27));
         end
         do_cell("cell_rand", rx, ry);
      end

      // Full redraw of an empty grid, cursor in the last cell.
      load_mem(0);
      cur_x = 5'd27; cur_y = 5'd27;
      model_full(27, 27);
      b_plot = plots.size(); b_done = n_done; b_busy = n_busy;
      redraw_req = 1'b1;
      tick(1);
      redraw_req = 1'b0;
      wait_idle("redraw", 20000);
      check("redraw_busy_cycles", n_busy - b_busy, 14113);
      check("redraw_done", n_done - b_done, 1);
      check("redraw_last_plot", plots[plots.size() - 1], {8'd121, 7'd115, 3'b100});
      cnt = 0;
      for (int i = b_plot; i < plots.size(); i++) if (plots[i][2:0] == 3'b100) cnt++;
      check("redraw_cursor_plots", cnt, 16);
      check_plots("redraw", b_plot);

      // Clear of an all-ones grid followed by its own redraw.
      load_mem(1);
      cur_x = 5'd9; cur_y = 5'd14;
      for (int i = 0; i < N; i++) ref_mem[i] = 1'b0;
      model_full(9, 14);
      b_plot = plots.size(); b_done = n_done; b_busy = n_busy; b_wr = wr_addr.size();
      cnt = n_wr_bad;
      clear_req = 1'b1;
      tick(1);
      clear_req = 1'b0;
      wait_idle("clear", 20000);
      check("clear_write_count", wr_addr.size() - b_wr, N);
      check("clear_write_data", n_wr_bad - cnt, 0);
      cnt = 0;
      for (int i = 0; i < N && b_wr + i < wr_addr.size(); i++) if (wr_addr[b_wr + i] != i) cnt++;
      check("clear_write_order", cnt, 0);
      check("clear_busy_cycles", n_busy - b_busy, N + 14113);
      check("clear_done", n_done - b_done, 1);
      cnt = 0;
      for (int i = b_plot; i < plots.size(); i++) if (plots[i][2:0] == 3'b000) cnt++;
      check("clear_ink_plots", cnt, 0);
      check_plots("clear", b_plot);

      // Redraw, then clear and a second redraw while busy: the redraw folds into the clear.
      load_mem(2);
      cur_x = 5'($urandom_range(0, 27)); cur_y = 5'($urandom_range(0, 27));
      model_full(int'(cur_x), int'(cur_y));
      for (int i = 0; i < N; i++) ref_mem[i] = 1'b0;
      model_full(int'(cur_x), int'(cur_y));
      b_plot = plots.size(); b_done = n_done; b_wr = wr_addr.size();
      redraw_req = 1'b1;
      tick(1);
      redraw_req = 1'b0;
      tick(99);
      clear_req = 1'b1;
      tick(1);
      clear_req = 1'b0;
      tick(50);
      redraw_req = 1'b1;
      tick(1);
      redraw_req = 1'b0;
      for (int k = 0; k < 40000 && (n_done - b_done) < 2; k++) @(negedge clk);
      tick(40);
      check("merge_done_count", n_done - b_done, 2);
      check("merge_idle", busy, 0);
      check("merge_write_count", wr_addr.size() - b_wr, N);
      check_plots("merge", b_plot);

      // Reset in the middle of a redraw, then a normal cell request.
      load_mem(2);
      redraw_req = 1'b1;
      tick(1);
      redraw_req = 1'b0;
      tick(499);
      resetn = 1'b0;
      tick(1);
      check("midrst_busy", busy, 0);
      check("midrst_plot", vga_plot, 0);
      check("midrst_done", done, 0);
      check("midrst_addr", mem_addr, 0);
      resetn = 1'b1;
      cur_x = 5'd2; cur_y = 5'd2;
      tick(1);
      do_cell("after_rst", 10, 20);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
